tx_word_sender: RTL and testbench

Upstream feeder for the debug unit's UART transmitter. The block accepts a wide word (default 32 bits) through a valid/ready handshake. It splits the word into bytes, least-significant byte first, and hands each byte to the transmitter with a one-cycle start pulse, waiting for the transmitter's done tick before issuing the next byte. It sits between the debug unit's command/response logic and the UART transmitter.

---
 rtl/tx_word_sender.sv | 108 ++++++++++
 tb/tb_tx_word_sender.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_word_sender.sv
// Splits a wide word into bytes, least-significant byte first, and feeds them
// one at a time to the UART transmitter using a start pulse / done tick handshake.
module tx_word_sender #(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_word_valid,
    input  logic [NB_WORD-1:0] i_word,
    output logic               o_word_ready,
    input  logic               i_tx_done_tick,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_word_done
);

    localparam int NBYTES = NB_WORD / NB_BYTE;
    localparam int NB_IDX = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [NB_IDX-1:0]  index_q, index_d;
    logic [NB_WORD-1:0] hold_q, hold_d;
    logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
    logic               word_done_q, word_done_d;
    logic [NB_WORD-1:0] hold_shift;
    logic               last_byte;

    // The hold register shifts right on every advance, so the next byte is
    // always found in the bottom slice regardless of the index value.
    assign hold_shift = hold_q >> NB_BYTE;
    assign last_byte  = (index_q == LAST_IDX);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            hold_q      <= '0;
            tx_data_q   <= '0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            hold_q      <= hold_d;
            tx_data_q   <= tx_data_d;
            word_done_q <= word_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_word_valid) state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_tx_done_tick) begin
                    state_d = last_byte ? ST_IDLE : ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        index_d     = index_q;
        hold_d      = hold_q;
        tx_data_d   = tx_data_q;
        word_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_word_valid) begin
                    hold_d    = i_word;
                    index_d   = '0;
                    tx_data_d = i_word[NB_BYTE-1:0];
                end
            end
            ST_WAIT: begin
                if (i_tx_done_tick) begin
                    if (!last_byte) begin
                        index_d   = index_q + 1'b1;
                        hold_d    = hold_shift;
                        tx_data_d = hold_shift[NB_BYTE-1:0];
                    end else begin
                        word_done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_tx_start   = (state_q == ST_SEND);
        o_busy       = (state_q != ST_IDLE);
        o_word_ready = (state_q == ST_IDLE);
        o_tx_data    = tx_data_q;
        o_word_done  = word_done_q;
    end

endmodule

// File: tb/tb_tx_word_sender.sv
// Scoreboard bench for tx_word_sender: 32-bit build driven by a transmitter
// model plus an 8-bit build exercised directly.
module tb_tx_word_sender;

   logic        clock = 1'b0;
   logic        reset;
   logic        wordValid;
   logic [31:0] word;
   logic        wordReady;
   logic        txDoneTick;
   logic        txStart;
   logic [7:0]  txData;
   logic        busy;
   logic        wordDone;

   logic        valid8;
   logic [7:0]  word8;
   logic        ready8;
   logic        done8;
   logic        start8;
   logic [7:0]  data8;
   logic        busy8;
   logic        wordDone8;

   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   int          startCount = 0;
   int          wordDoneCount = 0;
   int          lastDoneCyc = -1;
   bit          modelEn = 0;
   int          modelCnt = 0;
   bit          prevStart = 0;
   logic [7:0]  expQ[$];
   logic [7:0]  expQ8[$];

   always #5 clock = ~clock;

   tx_word_sender #(.NB_WORD(32), .NB_BYTE(8)) dut (
      .i_clock        (clock),
      .i_reset        (reset),
      .i_word_valid   (wordValid),
      .i_word         (word),
      .o_word_ready   (wordReady),
      .i_tx_done_tick (txDoneTick),
      .o_tx_start     (txStart),
      .o_tx_data      (txData),
      .o_busy         (busy),
      .o_word_done    (wordDone)
   );

   tx_word_sender #(.NB_WORD(8), .NB_BYTE(8)) dut8 (
      .i_clock        (clock),
      .i_reset        (reset),
      .i_word_valid   (valid8),
      .i_word         (word8),
      .o_word_ready   (ready8),
      .i_tx_done_tick (done8),
      .o_tx_start     (start8),
      .o_tx_data      (data8),
      .o_busy         (busy8),
      .o_word_done    (wordDone8)
   );

   // Free-running cycle number, bumped on the edge so every #1 reader agrees.
   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Transmitter model: raises its done tick 20 cycles after each start pulse.
   initial forever begin
      @(posedge clock);
      #1;
      if (modelEn) begin
         txDoneTick = 1'b0;
         if (modelCnt > 0) begin
            modelCnt--;
            if (modelCnt == 0) begin
               txDoneTick  = 1'b1;
               lastDoneCyc = cyc;
            end
         end
         if (txStart) modelCnt = 20;
      end else begin
         modelCnt = 0;
      end
   end

   // Scoreboard: every start pulse must carry the oldest expected byte.
   initial forever begin
      logic [7:0] expByte;
      @(posedge clock);
      #1;
      if (txStart) begin
         startCount++;
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_start: got start with data %h, expected no start", txData);
         end else begin
            expByte = expQ.pop_front();
            if (txData !== expByte) begin
               mismatched++;
               $display("[TB] FAIL byte_data: got %h, expected %h", txData, expByte);
            end
         end
         compared++;
         if (prevStart) begin
            mismatched++;
            $display("[TB] FAIL start_gap: got start in two consecutive cycles, expected gap >= 2");
         end
      end
      if (wordDone) wordDoneCount++;
      prevStart = txStart;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got simulation timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic waitWordDone(input int limit, output bit ok);
      ok = 0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (wordDone) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic pushWord(input logic [31:0] w);
      for (int b = 0; b < 4; b++) expQ.push_back(w[8*b +: 8]);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      compared++; if (txStart !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_start: got %b, expected 0", txStart); end
      compared++; if (txData !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_data: got %h, expected 00", txData); end
      compared++; if (wordReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b, expected 1", wordReady); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
      compared++; if (wordDone !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_word_done: got %b, expected 0", wordDone); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_word();
      int  startBase = startCount;
      int  doneBase = wordDoneCount;
      bit  seen = 0;
      bit  busyDropped = 0;
      modelEn = 1;
      pushWord(32'hA1B2C3D4);
      wordValid = 1'b1;
      word = 32'hA1B2C3D4;
      tick();
      wordValid = 1'b0;
      compared++; if (txStart !== 1'b1 || txData !== 8'hD4) begin mismatched++; $display("[TB] FAIL accept_start: got start=%b data=%h, expected 1/d4", txStart, txData); end
      compared++; if (busy !== 1'b1 || wordReady !== 1'b0) begin mismatched++; $display("[TB] FAIL accept_flags: got busy=%b ready=%b, expected 1/0", busy, wordReady); end
      for (int i = 0; i < 200; i++) begin
         tick();
         if (wordDone) begin seen = 1; break; end
         if (busy !== 1'b1) busyDropped = 1;
      end
      compared++; if (!seen) begin mismatched++; $display("[TB] FAIL single_timeout: got no word_done, expected one"); end
      compared++; if (busyDropped) begin mismatched++; $display("[TB] FAIL single_busy: got busy low mid-word, expected high"); end
      compared++; if (cyc !== lastDoneCyc + 1) begin mismatched++; $display("[TB] FAIL word_done_timing: got cycle %0d, expected %0d", cyc, lastDoneCyc + 1); end
      compared++; if (wordReady !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL done_flags: got ready=%b busy=%b, expected 1/0", wordReady, busy); end
      tick();
      compared++; if (wordDone !== 1'b0) begin mismatched++; $display("[TB] FAIL word_done_width: got %b, expected 0", wordDone); end
      for (int i = 0; i < 5; i++) tick();
      compared++; if (startCount - startBase !== 4) begin mismatched++; $display("[TB] FAIL single_starts: got %0d, expected 4", startCount - startBase); end
      compared++; if (wordDoneCount - doneBase !== 1) begin mismatched++; $display("[TB] FAIL single_done_count: got %0d, expected 1", wordDoneCount - doneBase); end
   endtask

   task automatic test_stray_done();
      modelEn = 0;
      txDoneTick = 1'b1;
      tick();
      txDoneTick = 1'b0;
      compared++; if (wordReady !== 1'b1 || busy !== 1'b0 || txStart !== 1'b0) begin mismatched++; $display("[TB] FAIL stray_idle: got ready=%b busy=%b start=%b, expected 1/0/0", wordReady, busy, txStart); end
      pushWord(32'h0A0B0C0D);
      wordValid = 1'b1;
      word = 32'h0A0B0C0D;
      tick();
      wordValid = 1'b0;
      txDoneTick = 1'b1;
      tick();
      txDoneTick = 1'b0;
      compared++; if (txStart !== 1'b0 || txData !== 8'h0D || busy !== 1'b1) begin mismatched++; $display("[TB] FAIL stray_send: got start=%b data=%h busy=%b, expected 0/0d/1", txStart, txData, busy); end
      tick();
      tick();
      compared++; if (txStart !== 1'b0) begin mismatched++; $display("[TB] FAIL stray_extra_start: got %b, expected 0", txStart); end
      for (int b = 0; b < 4; b++) begin
         txDoneTick = 1'b1;
         tick();
         txDoneTick = 1'b0;
         if (b < 3) begin
            compared++; if (txStart !== 1'b1) begin mismatched++; $display("[TB] FAIL stray_next_start%0d: got %b, expected 1", b, txStart); end
         end else begin
            compared++; if (wordDone !== 1'b1) begin mismatched++; $display("[TB] FAIL stray_word_done: got %b, expected 1", wordDone); end
         end
         tick();
      end
   endtask

   task automatic test_busy_ignore();
      bit ok;
      bit readySeen = 0;
      int startBase = startCount;
      modelEn = 1;
      pushWord(32'h13579BDF);
      wordValid = 1'b1;
      word = 32'h13579BDF;
      tick();
      word = 32'hDEADBEEF;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (wordReady !== 1'b0) readySeen = 1;
      end
      wordValid = 1'b0;
      compared++; if (readySeen) begin mismatched++; $display("[TB] FAIL busy_ready: got ready high while busy, expected 0"); end
      waitWordDone(200, ok);
      compared++; if (!ok) begin mismatched++; $display("[TB] FAIL busy_timeout: got no word_done, expected one"); end
      for (int i = 0; i < 30; i++) tick();
      compared++; if (startCount - startBase !== 4) begin mismatched++; $display("[TB] FAIL busy_starts: got %0d, expected 4", startCount - startBase); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int startBase = startCount;
      modelEn = 1;
      pushWord(32'h11223344);
      pushWord(32'h55667788);
      wordValid = 1'b1;
      word = 32'h11223344;
      tick();
      word = 32'h55667788;
      waitWordDone(200, ok);
      compared++; if (!ok) begin mismatched++; $display("[TB] FAIL b2b_timeout1: got no word_done, expected one"); end
      compared++; if (wordReady !== 1'b1 || cyc !== lastDoneCyc + 1) begin mismatched++; $display("[TB] FAIL b2b_ready: got ready=%b at cycle %0d, expected 1 at %0d", wordReady, cyc, lastDoneCyc + 1); end
      tick();
      wordValid = 1'b0;
      compared++; if (txStart !== 1'b1 || txData !== 8'h88 || cyc !== lastDoneCyc + 2) begin mismatched++; $display("[TB] FAIL b2b_first: got start=%b data=%h cycle %0d, expected 1/88 at %0d", txStart, txData, cyc, lastDoneCyc + 2); end
      waitWordDone(200, ok);
      compared++; if (!ok) begin mismatched++; $display("[TB] FAIL b2b_timeout2: got no word_done, expected one"); end
      for (int i = 0; i < 3; i++) tick();
      compared++; if (startCount - startBase !== 8) begin mismatched++; $display("[TB] FAIL b2b_starts: got %0d, expected 8", startCount - startBase); end
      compared++; if (expQ.size() !== 0) begin mismatched++; $display("[TB] FAIL b2b_leftover: got %0d bytes pending, expected 0", expQ.size()); end
   endtask

   task automatic test_reset_mid_word();
      bit ok;
      int seenStarts = 0;
      int doneBase;
      modelEn = 1;
      pushWord(32'hCAFEF00D);
      wordValid = 1'b1;
      word = 32'hCAFEF00D;
      tick();
      wordValid = 1'b0;
      if (txStart) seenStarts++;
      for (int i = 0; i < 100 && seenStarts < 2; i++) begin
         tick();
         if (txStart) seenStarts++;
      end
      compared++; if (seenStarts !== 2) begin mismatched++; $display("[TB] FAIL mid_second_start: got %0d starts, expected 2", seenStarts); end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      modelEn = 0;
      txDoneTick = 1'b0;
      expQ.delete();
      compared++; if (txStart !== 1'b0 || txData !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_reset_tx: got start=%b data=%h, expected 0/00", txStart, txData); end
      compared++; if (wordReady !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_flags: got ready=%b busy=%b, expected 1/0", wordReady, busy); end
      doneBase = wordDoneCount;
      for (int i = 0; i < 40; i++) tick();
      compared++; if (wordDoneCount !== doneBase) begin mismatched++; $display("[TB] FAIL mid_abort_done: got %0d word_done pulses, expected 0", wordDoneCount - doneBase); end
      modelEn = 1;
      pushWord(32'h01020304);
      wordValid = 1'b1;
      word = 32'h01020304;
      tick();
      wordValid = 1'b0;
      compared++; if (txData !== 8'h04) begin mismatched++; $display("[TB] FAIL mid_restart: got %h, expected 04", txData); end
      waitWordDone(200, ok);
      compared++; if (!ok) begin mismatched++; $display("[TB] FAIL mid_restart_timeout: got no word_done, expected one"); end
      tick();
   endtask

   task automatic test_nb_word8();
      logic [7:0] expByte;
      bit extraStart = 0;
      expQ8.push_back(8'h5A);
      valid8 = 1'b1;
      word8 = 8'h5A;
      tick();
      valid8 = 1'b0;
      compared++;
      if (start8 !== 1'b1) begin
         mismatched++; $display("[TB] FAIL nb8_start: got %b, expected 1", start8);
      end else begin
         expByte = expQ8.pop_front();
         compared++; if (data8 !== expByte) begin mismatched++; $display("[TB] FAIL nb8_data: got %h, expected %h", data8, expByte); end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (start8 !== 1'b0) extraStart = 1;
      end
      done8 = 1'b1;
      tick();
      done8 = 1'b0;
      compared++; if (wordDone8 !== 1'b1 || ready8 !== 1'b1 || busy8 !== 1'b0) begin mismatched++; $display("[TB] FAIL nb8_done: got done=%b ready=%b busy=%b, expected 1/1/0", wordDone8, ready8, busy8); end
      if (start8 !== 1'b0) extraStart = 1;
      tick();
      if (start8 !== 1'b0) extraStart = 1;
      compared++; if (extraStart) begin mismatched++; $display("[TB] FAIL nb8_extra_start: got extra start pulse, expected exactly one"); end
      compared++; if (wordDone8 !== 1'b0) begin mismatched++; $display("[TB] FAIL nb8_done_width: got %b, expected 0", wordDone8); end
      compared++; if (expQ8.size() !== 0) begin mismatched++; $display("[TB] FAIL nb8_leftover: got %0d, expected 0", expQ8.size()); end
   endtask

   // Runs every scenario in order and prints the single summary line.
   initial begin
      reset = 1'b1;
      wordValid = 1'b0;
      word = '0;
      txDoneTick = 1'b0;
      valid8 = 1'b0;
      word8 = '0;
      done8 = 1'b0;
      test_reset();
      test_single_word();
      test_stray_done();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_word();
      test_nb_word8();
      compared++; if (expQ.size() !== 0) begin mismatched++; $display("[TB] FAIL final_leftover: got %0d bytes pending, expected 0", expQ.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
